// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and window helper, used by this timing
// generator and by the downstream colour stage.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int CLK_DIV = 4;
  localparam int H_TOTAL = 800;
  localparam int H_SYNC  = 96;
  localparam int H_START = 144;
  localparam int H_END   = 783;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC  = 2;
  localparam int V_START = 35;
  localparam int V_END   = 514;

  // True when a count lies inside the inclusive range [lo, hi].
  function automatic logic in_window(input logic [COUNT_W-1:0] val,
                                     input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Board-clock divider: asserts tick on the clock where the divider sits on its
// last count, so the edge that samples tick is the pixel advance edge.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // A 1-bit counter is kept for CLK_DIV=1 so widths stay legal; it never moves.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // Free-running modulo-CLK_DIV counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with sync and visible-window flags.
// Flags are derived from the next count values and loaded on the same edge as
// the counts, so counts and flags always describe the same pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_START = vga_timing_pkg::H_START,
  parameter int H_END   = vga_timing_pkg::H_END,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_START = vga_timing_pkg::V_START,
  parameter int V_END   = vga_timing_pkg::V_END
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               pix_en,
  output logic               frame_start
);

  localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

  logic               tick;
  logic               h_wrap;
  logic               v_wrap;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;

  clk_en_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Position that the next advance moves to, wrapping line and frame.
  always_comb begin
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
    h_next = h_wrap ? '0 : hCount + 1'b1;
    v_next = vCount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vCount + 1'b1;
    end
  end

  // Counters, flags and strobes; everything holds between advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        hCount <= h_next;
        vCount <= v_next;
        hSync  <= (int'(h_next) >= H_SYNC);
        vSync  <= (int'(v_next) >= V_SYNC);
        bright <= in_window(h_next, H_START, H_END) &&
                  in_window(v_next, V_START, V_END);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (shrunk raster /4, shrunk raster /1,
// default raster) compared every cycle against a position-from-edge-count model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       pe;
    logic       fs;
  } obs_t;

  typedef struct {
    int div; int ht; int hs; int hst; int hend;
    int vt;  int vs; int vst; int vend;
  } tcfg_t;

  typedef struct {
    int   id;
    int   k;
    obs_t want;
  } lit_t;

  logic clk;
  logic rst_n;
  int   k;
  int   total;
  int   bad;
  int   last_fs0;
  int   last_fs1;

  tcfg_t cfg [3];
  obs_t  obs [3];
  lit_t  lits[$];

  logic [9:0] hc0, vc0, hc1, vc1, hc2, vc2;
  logic hs0, vs0, br0, pe0, fs0;
  logic hs1, vs1, br1, pe1, fs1;
  logic hs2, vs2, br2, pe2, fs2;

  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_START(5), .H_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_START(3), .V_END(9)
  ) dut_small (
    .clk(clk), .rst(rst_n), .hCount(hc0), .vCount(vc0), .hSync(hs0),
    .vSync(vs0), .bright(br0), .pix_en(pe0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_START(5), .H_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_START(3), .V_END(9)
  ) dut_div1 (
    .clk(clk), .rst(rst_n), .hCount(hc1), .vCount(vc1), .hSync(hs1),
    .vSync(vs1), .bright(br1), .pix_en(pe1), .frame_start(fs1)
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst_n), .hCount(hc2), .vCount(vc2), .hSync(hs2),
    .vSync(vs2), .bright(br2), .pix_en(pe2), .frame_start(fs2)
  );

  assign obs[0] = {hc0, vc0, hs0, vs0, br0, pe0, fs0};
  assign obs[1] = {hc1, vc1, hs1, vs1, br1, pe1, fs1};
  assign obs[2] = {hc2, vc2, hs2, vs2, br2, pe2, fs2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // After k edges out of reset there have been k/div advances; the raster
  // position is that number of pixels into the frame, modulo the frame size.
  function automatic obs_t model(input tcfg_t c, input int kk);
    obs_t o;
    int a, p, h, v;
    a = kk / c.div;
    p = a % (c.ht * c.vt);
    h = p % c.ht;
    v = p / c.ht;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = (h >= c.hs);
    o.vs = (v >= c.vs);
    o.br = (h >= c.hst) && (h <= c.hend) && (v >= c.vst) && (v <= c.vend);
    o.pe = (kk > 0) && ((kk % c.div) == 0);
    o.fs = o.pe && (p == 0);
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s k=%0d got h=%0d v=%0d hs=%b vs=%b br=%b pe=%b fs=%b want h=%0d v=%0d hs=%b vs=%b br=%b pe=%b fs=%b",
               name, k, got.h, got.v, got.hs, got.vs, got.br, got.pe, got.fs,
               want.h, want.v, want.hs, want.vs, want.br, want.pe, want.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic void add_lit(input int id, input int kk, input int h, input int v,
                                  input bit hs, input bit vs, input bit br,
                                  input bit pe, input bit fs);
    lit_t l;
    l.id = id;
    l.k  = kk;
    l.want = {10'(h), 10'(v), hs, vs, br, pe, fs};
    lits.push_back(l);
  endfunction

  // Per-cycle comparison against the model, hand-computed anchors, frame length.
  always @(negedge clk) begin
    check("small", obs[0], model(cfg[0], k));
    check("div1",  obs[1], model(cfg[1], k));
    check("deflt", obs[2], model(cfg[2], k));
    if (rst_n) begin
      foreach (lits[i]) begin
        if (lits[i].k == k) check($sformatf("lit%0d_k%0d", lits[i].id, k),
                                  obs[lits[i].id], lits[i].want);
      end
    end
    if (!rst_n) begin
      last_fs0 = -1;
      last_fs1 = -1;
    end else begin
      if (fs0) begin
        if (last_fs0 >= 0) check_int("frame_len_small", k - last_fs0, 960);
        last_fs0 = k;
      end
      if (fs1) begin
        if (last_fs1 >= 0) check_int("frame_len_div1", k - last_fs1, 240);
        last_fs1 = k;
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    last_fs0 = -1;
    last_fs1 = -1;
    cfg[0] = '{div:4, ht:20,  hs:3,  hst:5,   hend:17,  vt:12,  vs:2, vst:3,  vend:9};
    cfg[1] = '{div:1, ht:20,  hs:3,  hst:5,   hend:17,  vt:12,  vs:2, vst:3,  vend:9};
    cfg[2] = '{div:4, ht:800, hs:96, hst:144, hend:783, vt:525, vs:2, vst:35, vend:514};
    //        id  k    h   v  hs vs br pe fs
    add_lit(0,   1,   0,  0, 0, 0, 0, 0, 0);
    add_lit(0,   3,   0,  0, 0, 0, 0, 0, 0);
    add_lit(0,   4,   1,  0, 0, 0, 0, 1, 0);
    add_lit(0,   5,   1,  0, 0, 0, 0, 0, 0);
    add_lit(0,  12,   3,  0, 1, 0, 0, 1, 0);
    add_lit(0,  79,  19,  0, 1, 0, 0, 0, 0);
    add_lit(0,  80,   0,  1, 0, 0, 0, 1, 0);
    add_lit(0, 160,   0,  2, 0, 1, 0, 1, 0);
    add_lit(0, 256,   4,  3, 1, 1, 0, 1, 0);
    add_lit(0, 260,   5,  3, 1, 1, 1, 1, 0);
    add_lit(0, 312,  18,  3, 1, 1, 0, 1, 0);
    add_lit(0, 788,  17,  9, 1, 1, 1, 1, 0);
    add_lit(0, 820,   5, 10, 1, 1, 0, 1, 0);
    add_lit(0, 959,  19, 11, 1, 1, 0, 0, 0);
    add_lit(0, 960,   0,  0, 0, 0, 0, 1, 1);
    add_lit(0, 961,   0,  0, 0, 0, 0, 0, 0);
    add_lit(1,   1,   1,  0, 0, 0, 0, 1, 0);
    add_lit(1,  20,   0,  1, 0, 0, 0, 1, 0);
    add_lit(1, 240,   0,  0, 0, 0, 0, 1, 1);
    add_lit(2,   4,   1,  0, 0, 0, 0, 1, 0);
    add_lit(2, 383,  95,  0, 0, 0, 0, 0, 0);
    add_lit(2, 384,  96,  0, 1, 0, 0, 1, 0);
    add_lit(2, 3200,  0,  1, 0, 0, 0, 1, 0);

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3500) @(posedge clk);

    // Random asynchronous resets dropped between edges at arbitrary positions.
    for (int it = 0; it < 8; it++) begin
      #2 rst_n = 1'b0;
      #1;
      check("async_small", obs[0], '0);
      check("async_div1",  obs[1], '0);
      check("async_deflt", obs[2], '0);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat ($urandom_range(30, 2500)) @(posedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
